// File: rtl/mult_div_if.sv
// Operand/result bundle between the pipeline and the HI/LO multiply-divide unit.
// The master drives requests; the unit (slave) returns status and the HI/LO registers.
interface mult_div_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_data, rt_data, mthi, mtlo,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, mthi, mtlo,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Fixed 34-edge latency: latch, ITER shift-add or restoring-divide steps, sign fix-up.
module mult_div_unit #(
   parameter int ITER = 32
) (
   input logic       clk,
   input logic       rst_n,
   mult_div_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [1:0]  op_q;
   logic        a_neg, b_neg;
   logic [31:0] m_q;
   logic [63:0] acc;
   logic [31:0] hi_q, lo_q;
   logic        done_q, dz_q;

   logic        in_signed, in_a_neg, in_b_neg;
   logic [31:0] in_a_mag, in_b_mag;
   logic [32:0] mul_sum, div_shift, div_rem;
   logic        div_ge;
   logic [63:0] step;
   logic        res_neg;
   logic [31:0] fix_hi, fix_lo;

   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

   // Signed ops iterate on magnitudes; signs are restored in FIX.
   assign in_signed = ~bus.op[0];
   assign in_a_neg  = in_signed & bus.rs_data[31];
   assign in_b_neg  = in_signed & bus.rt_data[31];
   assign in_a_mag  = in_a_neg ? 32'd0 - bus.rs_data : bus.rs_data;
   assign in_b_mag  = in_b_neg ? 32'd0 - bus.rt_data : bus.rt_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt == 6'(ITER - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One iteration: acc[63:32] is the partial product / remainder, acc[31:0] the
   // multiplier being shifted out / dividend shifted out as quotient bits shift in.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m_q} : 33'd0);
      div_shift = {acc[63:32], acc[31]};
      div_ge    = (div_shift >= {1'b0, m_q});
      div_rem   = div_ge ? div_shift - {1'b0, m_q} : div_shift;
      step      = op_q[1] ? {div_rem[31:0], acc[30:0], div_ge} : {mul_sum, acc[31:1]};
   end

   always_comb begin
      res_neg = ~op_q[0] & (a_neg ^ b_neg);
      fix_hi  = acc[63:32];
      fix_lo  = acc[31:0];
      if (op_q[1]) begin
         // Quotient sign follows the operand signs; remainder follows the dividend.
         fix_lo = res_neg ? 32'd0 - acc[31:0] : acc[31:0];
         fix_hi = (~op_q[0] & a_neg) ? 32'd0 - acc[63:32] : acc[63:32];
      end else if (res_neg) begin
         {fix_hi, fix_lo} = 64'd0 - acc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every datapath register is reset so an aborted operation leaves nothing stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         op_q   <= '0;
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         m_q    <= '0;
         acc    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q  <= bus.op;
                  a_neg <= in_a_neg;
                  b_neg <= in_b_neg;
                  cnt   <= '0;
                  dz_q  <= 1'b0;
                  if (bus.op[1]) begin
                     m_q <= in_b_mag;
                     acc <= {32'd0, in_a_mag};
                  end else begin
                     m_q <= in_a_mag;
                     acc <= {32'd0, in_b_mag};
                  end
               end else begin
                  if (bus.mthi) hi_q <= bus.rs_data;
                  if (bus.mtlo) lo_q <= bus.rs_data;
               end
            end
            CALC: begin
               acc <= step;
               cnt <= cnt + 6'd1;
            end
            FIX: begin
               if (op_q[1] && (m_q == 32'd0)) begin
                  dz_q <= 1'b1;
               end else begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
